line_buf_arb: RTL and testbench
===============================

Name: line_buf_arb

Overview:
- Burst-locked round-robin arbiter sharing the single-ported line-buffer SRAM between NUM_REQ masters.
- The masters are the refill writer, the evict reader and the core lookup port.
- Each master issues word beats with req/gnt. The arbiter locks the port to one master until that master's last beat, then rotates priority.
- Read data returns from the SRAM in order. It is steered back to the issuing master through an owner-ID FIFO.

Parameters:
NUM_REQ, 3, number of masters (2..8)
ADDR_W, 7, SRAM word-address width (clog2(list_depth*list_width))
DATA_W, 32, data width
RD_OUTST, 4, max outstanding reads (owner FIFO depth, power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-master beat request; must hold with payload stable until gnt
we  in  NUM_REQ  per-master 1=write beat, 0=read beat
last  in  NUM_REQ  per-master final beat of burst
addr  in  NUM_REQ*ADDR_W  per-master address; master i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  per-master write data, same packing
gnt  out  NUM_REQ  beat accepted this cycle
rvalid  out  NUM_REQ  read data valid for master i
rdata  out  DATA_W  shared read data (qualified by rvalid)
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_ready  in  1  SRAM accepts access when mem_en&&mem_ready
mem_rdata  in  DATA_W  SRAM read data
mem_rvalid  in  1  read data valid; in issue order, latency >=1
owner  out  clog2(NUM_REQ)  current lock owner (valid when busy)
busy  out  1  state==LOCK
rsp_err  out  1  sticky: mem_rvalid seen with owner FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; rr pointer=0; owner=0; owner FIFO emptied; rsp_err=0.
  - All outputs are 0: gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
  - Reads in flight at reset are discarded.
- FSM with two states, IDLE and LOCK.
- IDLE:
  - mem_en=0 and gnt=0.
  - If any req is high, select the first requesting index at or after the rr pointer (cyclic search).
  - Register it into owner and go to LOCK next cycle. Arbitration therefore costs exactly 1 bubble cycle.
- LOCK, issue condition:
  - mem_en = req[owner] && !(~we[owner] && fifo_full).
  - mem_we, mem_addr and mem_wdata are taken combinationally from the owner slice. They are 0 when mem_en=0.
  - gnt[owner] = mem_en && mem_ready. All other gnt bits are 0.
- LOCK, burst end:
  - A granted beat with last[owner]=1 ends the burst. Next state is IDLE, and the rr pointer becomes (owner+1) mod NUM_REQ.
  - req[owner] dropping mid-burst does not release the lock. The arbiter waits indefinitely; no other master is granted.
  - A single-beat burst (last=1 on the first beat) is legal.
- Read tracking:
  - A granted read pushes owner into the owner FIFO.
  - mem_rvalid pops the FIFO. For the popped ID i, rvalid[i]=1 and rdata=mem_rdata, combinationally in the same cycle.
  - Push and pop in the same cycle are allowed at any occupancy, including full: the count is unchanged.
  - The full check uses the registered count, so a full FIFO blocks issue even if a pop occurs that cycle.
  - Read responses keep flowing in IDLE and after the owner changes.
- rsp_err:
  - Set when mem_rvalid arrives with the FIFO empty. The data is dropped and no rvalid is driven.
  - Cleared only by reset.
- Writes carry no response.
- gnt goes to the owner only, never to another master in the same cycle.

Test Plan:
- Single master 0 issues a 4-beat write burst (addr 0x10..0x13) with mem_ready=1. Required: 1 idle cycle, then gnt[0] on 4 consecutive cycles; mem_we=1; back to IDLE after the last beat; rr pointer=1.
- Masters 0, 1 and 2 request simultaneously from reset, each with a 2-beat burst. Required: grant order 0,1,2, with 1 bubble cycle between bursts; owner values 0,1,2.
- Master 1 issues a read burst of 6 with RD_OUTST=4 and mem_rvalid delayed 10 cycles. Required: 4 grants, then mem_en=0 until the first mem_rvalid; then one more grant per pop; rvalid[1] is pulsed 6 times with the matching data.
- Master 2 drops req after beat 1 of 3 for 5 cycles while master 0 requests. Required: gnt[0] stays 0 and owner stays 2; the burst resumes and completes; then master 0 is granted.
- Master 2 has 2 reads outstanding; lock passes to master 0, which writes. Required: the responses assert rvalid[2] (not rvalid[0]) during master 0's burst.
- Two cases, run separately:
  - mem_rvalid pulses with nothing outstanding. Required: rsp_err=1 and stays set; no rvalid.
  - rst_n pulses low mid-burst. Required: all outputs are 0 immediately and the FIFO is empty.

Source files
------------

// File: rtl/line_buf_arb.sv
// rtl/line_buf_arb.sv - burst-locked round-robin arbiter for the line-buffer SRAM
// Read responses are routed back to their issuer through an in-order owner-ID FIFO.
module line_buf_arb #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int RD_OUTST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ-1:0]          last,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_rvalid,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    output logic                        rsp_err
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(RD_OUTST);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [OWN_W:0]   NREQ_EXT = (OWN_W + 1)'(NUM_REQ);
    localparam logic [OWN_W-1:0] LAST_ID  = OWN_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RD_OUTST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RD_OUTST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [OWN_W-1:0]  owner_nxt;
    logic [OWN_W-1:0]  rr_ptr;
    logic [OWN_W-1:0]  rr_nxt;
    logic [OWN_W-1:0]  sel;
    logic [OWN_W-1:0]  cand;
    logic [OWN_W:0]    cand_sum;
    logic              found;
    logic              fire;

    logic [OWN_W-1:0]  fifo_mem [RD_OUTST];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [OWN_W-1:0]  pop_id;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        sel      = rr_ptr;
        found    = 1'b0;
        cand     = '0;
        cand_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (OWN_W + 1)'(k);
            if (cand_sum >= NREQ_EXT) begin
                cand_sum = cand_sum - NREQ_EXT;
            end
            cand = cand_sum[OWN_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        gnt       = '0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt = sel;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                // Reads stall while the owner FIFO is full; writes never need a slot.
                if (req[owner] && (we[owner] || !fifo_full)) begin
                    mem_en    = 1'b1;
                    mem_we    = we[owner];
                    mem_addr  = addr[owner*ADDR_W +: ADDR_W];
                    mem_wdata = wdata[owner*DATA_W +: DATA_W];
                end
                fire       = mem_en && mem_ready;
                gnt[owner] = fire;
                if (fire && last[owner]) begin
                    state_nxt = IDLE;
                    rr_nxt    = (owner == LAST_ID) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == LOCK);
    assign fifo_full = (count == FULL_CNT);
    assign push      = fire && !mem_we;
    assign pop       = mem_rvalid && (count != '0);
    assign pop_id    = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid[i] = pop && (pop_id == OWN_W'(i));
        end
    end

    assign rdata = pop ? mem_rdata : '0;

    // An orphan response is dropped and flagged until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (mem_rvalid && (count == '0)) begin
            rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_line_buf_arb.sv
// tb/tb_line_buf_arb.sv - directed self-checking bench for line_buf_arb
// Includes a fixed-latency SRAM read responder returning 0xD00D0000 | addr.
module tb_line_buf_arb;

    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;
    localparam int RD_OUTST = 4;
    localparam int RD_LAT   = 10;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ-1:0]         we = '0;
    logic [NUM_REQ-1:0]         last = '0;
    logic [NUM_REQ*ADDR_W-1:0]  addr = '0;
    logic [NUM_REQ*DATA_W-1:0]  wdata = '0;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         rvalid;
    logic [DATA_W-1:0]          rdata;
    logic                       mem_en;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic                       mem_ready = 1'b1;
    logic [DATA_W-1:0]          mem_rdata = '0;
    logic                       mem_rvalid = 1'b0;
    logic [1:0]                 owner;
    logic                       busy;
    logic                       rsp_err;

    int errors = 0;
    int checks = 0;
    int cc = 0;
    int due_q[$];
    logic [DATA_W-1:0] dat_q[$];

    line_buf_arb #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_OUTST(RD_OUTST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .last(last), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .owner(owner), .busy(busy), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cc++;
        if (due_q.size() > 0 && due_q[0] <= cc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && mem_en && mem_ready && !mem_we) begin
            due_q.push_back(cc + RD_LAT);
            dat_q.push_back(32'hD00D_0000 | 32'(mem_addr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int i, input logic r, input logic w, input logic l,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i]  = r;
        we[i]   = w;
        last[i] = l;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        req = '0; we = '0; last = '0; addr = '0; wdata = '0; mem_ready = 1'b1;
        due_q.delete();
        dat_q.delete();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en_we: got %b%b expected 00", mem_en, mem_we); end
        checks++; if (mem_addr !== 7'h00 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL reset_buses: got %h %h %h expected zeros", mem_addr, mem_wdata, rdata); end
        checks++; if (busy !== 1'b0 || owner !== 2'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_state: got busy=%b owner=%0d rsp_err=%b expected 0 0 0", busy, owner, rsp_err); end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 7'h10, 32'hA000_0010);
        #1;
        checks++; if (gnt !== 3'b000 || mem_en !== 1'b0) begin errors++; $display("FAIL single_bubble: got gnt=%b mem_en=%b expected 000 0", gnt, mem_en); end
        cyc();
        for (int b = 0; b < 4; b++) begin
            drive(0, 1'b1, 1'b1, b == 3, 7'h10 + 7'(b), 32'hA000_0010 + 32'(b));
            #1;
            checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt b%0d: got %b expected 001", b, gnt); end
            checks++; if (mem_we !== 1'b1 || mem_addr !== 7'h10 + 7'(b)) begin errors++; $display("FAIL single_addr b%0d: got we=%b addr=%h expected 1 %h", b, mem_we, mem_addr, 7'h10 + 7'(b)); end
            checks++; if (mem_wdata !== 32'hA000_0010 + 32'(b)) begin errors++; $display("FAIL single_wdata b%0d: got %h expected %h", b, mem_wdata, 32'hA000_0010 + 32'(b)); end
            cyc();
        end
        drive(0, 1'b1, 1'b1, 1'b1, 7'h05, 32'h0000_0005);
        drive(2, 1'b1, 1'b1, 1'b1, 7'h06, 32'h0000_0006);
        #1;
        checks++; if (busy !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL single_idle: got busy=%b gnt=%b expected 0 000", busy, gnt); end
        cyc();
        #1;
        checks++; if (owner !== 2'd2 || gnt !== 3'b100) begin errors++; $display("FAIL rr_after_write: got owner=%0d gnt=%b expected 2 100", owner, gnt); end
        cyc();
        drive(2, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle2: got busy=%b expected 0", busy); end
        cyc();
        #1;
        checks++; if (owner !== 2'd0 || gnt !== 3'b001) begin errors++; $display("FAIL rr_wrap: got owner=%0d gnt=%b expected 0 001", owner, gnt); end
        cyc();
        drive(0, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
    endtask

    task automatic test_round_robin();
        logic [2:0] e;
        do_reset();
        for (int m = 0; m < 3; m++) drive(m, 1'b1, 1'b1, 1'b0, 7'(8 * m), 32'(m));
        for (int m = 0; m < 3; m++) begin
            e = 3'b001 << m;
            #1;
            checks++; if (busy !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL rr_bubble m%0d: got busy=%b gnt=%b expected 0 000", m, busy, gnt); end
            cyc();
            #1;
            checks++; if (owner !== 2'(m) || gnt !== e) begin errors++; $display("FAIL rr_beat0 m%0d: got owner=%0d gnt=%b expected %0d %b", m, owner, gnt, m, e); end
            cyc();
            drive(m, 1'b1, 1'b1, 1'b1, 7'(8 * m + 1), 32'(m));
            #1;
            checks++; if (gnt !== e) begin errors++; $display("FAIL rr_beat1 m%0d: got %b expected %b", m, gnt, e); end
            cyc();
            drive(m, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
        end
    endtask

    task automatic test_read_backpressure();
        int exp_g[6] = '{1, 2, 3, 4, 12, 13};
        int exp_r[6] = '{11, 12, 13, 14, 22, 23};
        int g = 0;
        int nrv = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            drive(1, g < 6, 1'b0, g == 5, 7'h20 + 7'(g), 32'h0);
            #1;
            if (gnt[1]) begin
                checks++; if (g >= 6 || c != exp_g[g]) begin errors++; $display("FAIL rd_gnt_cycle g%0d: got cycle %0d expected %0d", g, c, (g < 6) ? exp_g[g] : -1); end
                g++;
            end
            if (rvalid[1]) begin
                checks++; if (nrv >= 6 || c != exp_r[nrv] || rdata !== 32'hD00D_0020 + 32'(nrv)) begin errors++; $display("FAIL rd_rvalid n%0d: got cycle %0d data %h expected %0d %h", nrv, c, rdata, (nrv < 6) ? exp_r[nrv] : -1, 32'hD00D_0020 + 32'(nrv)); end
                nrv++;
            end
            if (c >= 5 && c <= 11) begin
                checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rd_full_stall c%0d: got mem_en=%b expected 0", c, mem_en); end
            end
            checks++; if ((rvalid & 3'b101) !== 3'b000) begin errors++; $display("FAIL rd_other_rvalid c%0d: got %b expected x0x clear", c, rvalid); end
            cyc();
        end
        checks++; if (g != 6 || nrv != 6) begin errors++; $display("FAIL rd_totals: got grants=%0d rvalids=%0d expected 6 6", g, nrv); end
    endtask

    task automatic test_hold_lock();
        do_reset();
        drive(2, 1'b1, 1'b1, 1'b0, 7'h30, 32'hC030);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_bubble: got busy=%b expected 0", busy); end
        cyc();
        #1;
        checks++; if (owner !== 2'd2 || gnt !== 3'b100) begin errors++; $display("FAIL hold_beat0: got owner=%0d gnt=%b expected 2 100", owner, gnt); end
        cyc();
        drive(2, 1'b0, 1'b1, 1'b0, 7'h31, 32'hC031);
        drive(0, 1'b1, 1'b1, 1'b1, 7'h40, 32'hC040);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (gnt !== 3'b000 || owner !== 2'd2 || busy !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL hold_gap c%0d: got gnt=%b owner=%0d busy=%b mem_en=%b expected 000 2 1 0", c, gnt, owner, busy, mem_en); end
            cyc();
        end
        drive(2, 1'b1, 1'b1, 1'b0, 7'h31, 32'hC031);
        mem_ready = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b1 || gnt !== 3'b000) begin errors++; $display("FAIL hold_not_ready: got mem_en=%b gnt=%b expected 1 000", mem_en, gnt); end
        cyc();
        mem_ready = 1'b1;
        #1;
        checks++; if (gnt !== 3'b100 || mem_addr !== 7'h31) begin errors++; $display("FAIL hold_beat1: got gnt=%b addr=%h expected 100 31", gnt, mem_addr); end
        cyc();
        drive(2, 1'b1, 1'b1, 1'b1, 7'h32, 32'hC032);
        #1;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL hold_beat2: got %b expected 100", gnt); end
        cyc();
        drive(2, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
        #1;
        checks++; if (busy !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL hold_release: got busy=%b gnt=%b expected 0 000", busy, gnt); end
        cyc();
        #1;
        checks++; if (owner !== 2'd0 || gnt !== 3'b001) begin errors++; $display("FAIL hold_next: got owner=%0d gnt=%b expected 0 001", owner, gnt); end
        cyc();
        drive(0, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
    endtask

    task automatic test_resp_steer();
        int g0 = 0;
        int g2 = 0;
        int n2 = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(2, g2 < 2, 1'b0, g2 == 1, 7'h50 + 7'(g2), 32'h0);
            drive(0, c >= 3 && g0 < 10, 1'b1, g0 == 9, 7'h60 + 7'(g0), 32'hE000_0000 + 32'(g0));
            #1;
            if (gnt[2]) g2++;
            if (gnt[0]) g0++;
            if (rvalid[2]) n2++;
            checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL steer_rvalid0 c%0d: got %b expected 0", c, rvalid[0]); end
            if (c == 11 || c == 12) begin
                checks++; if (rvalid !== 3'b100 || rdata !== 32'hD00D_0050 + 32'(c - 11)) begin errors++; $display("FAIL steer_resp c%0d: got rvalid=%b data=%h expected 100 %h", c, rvalid, rdata, 32'hD00D_0050 + 32'(c - 11)); end
                checks++; if (owner !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL steer_owner c%0d: got owner=%0d busy=%b expected 0 1", c, owner, busy); end
            end
            cyc();
        end
        checks++; if (g0 != 10 || g2 != 2 || n2 != 2) begin errors++; $display("FAIL steer_totals: got g0=%0d g2=%0d n2=%0d expected 10 2 2", g0, g2, n2); end
        drive(0, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
        drive(2, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
    endtask

    task automatic test_rsp_err();
        do_reset();
        #1;
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b expected 0", rsp_err); end
        due_q.push_back(cc + 1);
        dat_q.push_back(32'h0000_0BAD);
        cyc();
        #1;
        checks++; if (rvalid !== 3'b000 || rdata !== 32'h0) begin errors++; $display("FAIL err_no_rvalid: got rvalid=%b data=%h expected 000 0", rvalid, rdata); end
        cyc();
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", rsp_err); end
        repeat (5) cyc();
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", rsp_err); end
    endtask

    task automatic test_mid_reset();
        int g0 = 0;
        int g1 = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, g1 < 2, 1'b0, g1 == 1, 7'h70 + 7'(g1), 32'h0);
            drive(0, c >= 3, 1'b1, 1'b0, 7'h78 + 7'(g0), 32'hF000_0000 + 32'(g0));
            #1;
            if (gnt[1]) g1++;
            if (gnt[0]) g0++;
            cyc();
        end
        #1;
        checks++; if (busy !== 1'b1 || g0 != 2 || g1 != 2) begin errors++; $display("FAIL mrst_pre: got busy=%b g0=%0d g1=%0d expected 1 2 2", busy, g0, g1); end
        rst_n = 1'b0;
        due_q.delete();
        dat_q.delete();
        #1;
        checks++; if (gnt !== 3'b000 || mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_ctrl: got gnt=%b en=%b we=%b busy=%b expected 000 0 0 0", gnt, mem_en, mem_we, busy); end
        checks++; if (mem_addr !== 7'h00 || mem_wdata !== 32'h0 || rvalid !== 3'b000 || rdata !== 32'h0 || owner !== 2'd0) begin errors++; $display("FAIL mrst_data: got addr=%h wdata=%h rvalid=%b rdata=%h owner=%0d expected zeros", mem_addr, mem_wdata, rvalid, rdata, owner); end
        drive(0, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
        cyc();
        rst_n = 1'b1;
        due_q.push_back(cc + 1);
        dat_q.push_back(32'h0000_0070);
        cyc();
        #1;
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL mrst_fifo_rvalid: got %b expected 000", rvalid); end
        cyc();
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL mrst_fifo_empty: got rsp_err=%b expected 1", rsp_err); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_backpressure();
        test_hold_lock();
        test_resp_steer();
        test_rsp_err();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
